// File: rtl/spi_slave_core.sv
// SPI slave with generic word width, all four SPI modes, selectable bit order and
// valid/ready streams for received and transmitted words, fully clocked on clk.
module spi_slave_core #(
  parameter int                DATA_W    = 8,
  parameter int                CPOL      = 0,
  parameter int                CPHA      = 0,
  parameter int                MSB_FIRST = 1,
  parameter logic [DATA_W-1:0] TX_IDLE   = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              sck,
  input  logic              ssel_n,
  input  logic              mosi,
  output logic              miso,
  output logic              miso_oe,
  output logic [DATA_W-1:0] rx_data,
  output logic              rx_valid,
  input  logic              rx_ready,
  input  logic [DATA_W-1:0] tx_data,
  input  logic              tx_valid,
  output logic              tx_ready,
  output logic              rx_overrun,
  output logic              tx_underrun,
  output logic              busy
);
  localparam int             CW     = (DATA_W > 2) ? $clog2(DATA_W) : 1;
  localparam logic [CW-1:0]  LAST   = CW'(DATA_W - 1);
  localparam bit             CPOL_B = (CPOL != 0);
  localparam bit             CPHA_B = (CPHA != 0);
  localparam bit             MSB_B  = (MSB_FIRST != 0);

  typedef enum logic {IDLE, ACTIVE} state_t;

  state_t            state_q, state_d;
  logic [2:0]        sck_s, ssel_s;
  logic [1:0]        mosi_s;
  logic [CW-1:0]     bit_cnt;
  logic [DATA_W-1:0] rx_sr, tx_sr, hold_q;
  logic              hold_full, done_q;
  logic              lead, trail, sample_e, shift_e, ssel_fall, ssel_rise;
  logic              do_sample, load, advance, hold_wr;

  // sck is normalised by CPOL so that "lead" is always a rising edge
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sck_s  <= '0;
      ssel_s <= '1;
      mosi_s <= '0;
    end else begin
      sck_s  <= {sck_s[1:0], sck ^ CPOL_B};
      ssel_s <= {ssel_s[1:0], ssel_n};
      mosi_s <= {mosi_s[0], mosi};
    end
  end

  assign lead      =  sck_s[1] & ~sck_s[2];
  assign trail     = ~sck_s[1] &  sck_s[2];
  assign sample_e  = CPHA_B ? trail : lead;
  assign shift_e   = CPHA_B ? lead  : trail;
  assign ssel_fall = ~ssel_s[1] &  ssel_s[2];
  assign ssel_rise =  ssel_s[1] & ~ssel_s[2];
  assign hold_wr   = tx_valid & ~hold_full;

  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // In mode 0/2 the trailing edge after a completed word must not disturb the
  // freshly loaded next word, hence no advance while the bit counter is 0.
  always_comb begin
    state_d   = state_q;
    do_sample = 1'b0;
    load      = 1'b0;
    advance   = 1'b0;
    case (state_q)
      IDLE: begin
        if (ssel_fall) begin
          state_d = ACTIVE;
          load    = ~CPHA_B;
        end
      end
      ACTIVE: begin
        if (ssel_rise) begin
          state_d = IDLE;
        end else begin
          do_sample = sample_e;
          if (CPHA_B) load = shift_e & (bit_cnt == '0);
          else        load = done_q;
          advance = shift_e & ~load & (CPHA_B | (bit_cnt != '0));
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      bit_cnt <= '0;
      rx_sr   <= '0;
      done_q  <= 1'b0;
    end else begin
      done_q <= do_sample & (bit_cnt == LAST);
      if (state_q == ACTIVE && ssel_rise) begin
        bit_cnt <= '0;
      end else if (do_sample) begin
        rx_sr   <= MSB_B ? {rx_sr[DATA_W-2:0], mosi_s[1]} : {mosi_s[1], rx_sr[DATA_W-1:1]};
        bit_cnt <= (bit_cnt == LAST) ? '0 : bit_cnt + 1'b1;
      end
    end
  end

  // A completed word is offered the cycle after its last sample
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rx_data    <= '0;
      rx_valid   <= 1'b0;
      rx_overrun <= 1'b0;
    end else begin
      rx_overrun <= 1'b0;
      if (done_q) begin
        if (!rx_valid || rx_ready) begin
          rx_data  <= rx_sr;
          rx_valid <= 1'b1;
        end else begin
          rx_overrun <= 1'b1;
        end
      end else if (rx_valid && rx_ready) begin
        rx_valid <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      hold_q      <= '0;
      hold_full   <= 1'b0;
      tx_sr       <= '0;
      tx_underrun <= 1'b0;
    end else begin
      tx_underrun <= load & ~hold_full;
      if (hold_wr) hold_q <= tx_data;
      if (hold_wr)   hold_full <= 1'b1;
      else if (load) hold_full <= 1'b0;
      if (load)
        tx_sr <= hold_full ? hold_q : TX_IDLE;
      else if (advance)
        tx_sr <= MSB_B ? {tx_sr[DATA_W-2:0], 1'b0} : {1'b0, tx_sr[DATA_W-1:1]};
    end
  end

  assign busy     = (state_q == ACTIVE);
  assign miso_oe  = busy;
  assign miso     = busy & (MSB_B ? tx_sr[DATA_W-1] : tx_sr[0]);
  assign tx_ready = ~hold_full;

endmodule
